seq_to_par: RTL

//   Serial-to-parallel receiver: the far end of the par-to-seq shifter. Collects

---
 rtl/seq_to_par.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_to_par.sv
// Serial-to-parallel receiver: assembles WIDTH LSB-first serial bits into a word
// and offers it through a valid/ready holding register with overrun/resync status.
module seq_to_par #(
    parameter int WIDTH     = 4,
    parameter bit START_REQ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             resync
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {HUNT, COLLECT} state_t;
    localparam state_t IDLE_STATE = state_t'(START_REQ ? HUNT : COLLECT);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_sr, w_sr_nxt, w_word;
    logic             w_complete, w_resync, w_buf_free;

    assign w_word     = {in_bit, r_sr[WIDTH-1:1]};
    assign w_buf_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_STATE;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sr    <= w_sr_nxt;
        end
    end

    // An in_start mid-frame (including on the would-be last bit) restarts the
    // frame with this bit as bit 0; stale sr bits shift out before completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_complete  = 1'b0;
        w_resync    = 1'b0;
        case (r_state)
            HUNT: begin
                if (in_valid && in_start) begin
                    w_sr_nxt    = w_word;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    w_sr_nxt = w_word;
                    if (in_start && r_cnt != '0) begin
                        w_resync  = 1'b1;
                        w_cnt_nxt = CW'(1);
                    end else if (r_cnt == LAST) begin
                        w_complete  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE_STATE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            resync    <= 1'b0;
        end else begin
            resync <= w_resync;
            if (w_complete && w_buf_free) begin
                out_data  <= w_word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_complete && !w_buf_free) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
